// File: rtl/mem_line_packer_if.sv
// rtl/mem_line_packer_if.sv - word-in / line-out handshake bundle for mem_line_packer
interface mem_line_packer_if #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WORD_W-1:0]       in_data;
    logic                    in_last;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WORD_W*WORDS:0]   out_frame;
    logic [WORDS-1:0]        out_mask;

    // Producer of words and consumer of frames
    modport master (
        output in_valid, in_data, in_last, flush, out_ready,
        input  in_ready, out_valid, out_frame, out_mask
    );

    // The packer itself
    modport slave (
        input  in_valid, in_data, in_last, flush, out_ready,
        output in_ready, out_valid, out_frame, out_mask
    );
endinterface

// File: rtl/mem_line_packer.sv
// rtl/mem_line_packer.sv - packs 32-bit words into 129-bit {partial, line} frames
module mem_line_packer #(
    parameter int WORD_W        = 32,
    parameter int WORDS         = 4,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_line_packer_if.slave   bus
);
    localparam int LINE_W = WORD_W * WORDS;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    // S_PEND: a closed line waits in the assembly register for the output register
    typedef enum logic {S_FILL, S_PEND} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LINE_W-1:0]    asm_data_q, asm_data_d;
    logic [WORDS-1:0]     asm_mask_q, asm_mask_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic                 out_valid_q, out_valid_d;
    logic [LINE_W:0]      out_frame_q, out_frame_d;
    logic [WORDS-1:0]     out_mask_q, out_mask_d;

    logic                 accept;
    logic                 out_free;
    logic                 close;
    logic                 load_en;
    logic [LINE_W-1:0]    line_data;
    logic [WORDS-1:0]     line_mask;
    logic [LINE_W-1:0]    load_data;
    logic [WORDS-1:0]     load_mask;

    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_frame = out_frame_q;
    assign bus.out_mask  = out_mask_q;

    // Next-state: merge the incoming word, decide on a close, and move lines downstream
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_data_d  = asm_data_q;
        asm_mask_d  = asm_mask_q;
        idle_d      = '0;
        out_valid_d = out_valid_q;
        out_frame_d = out_frame_q;
        out_mask_d  = out_mask_q;
        load_en     = 1'b0;
        load_data   = asm_data_q;
        load_mask   = asm_mask_q;
        close       = 1'b0;

        accept   = bus.in_valid && (state_q == S_FILL);
        out_free = !out_valid_q || bus.out_ready;

        // The line as it will look after this edge, including a word accepted now
        line_data = asm_data_q;
        line_mask = asm_mask_q;
        if (accept) begin
            line_data[int'(cnt_q)*WORD_W +: WORD_W] = bus.in_data;
            line_mask[cnt_q] = 1'b1;
        end

        // Word-, flush- and timeout-driven closes collapse into one event
        if (state_q == S_FILL) begin
            if (accept && ((cnt_q == CNT_W'(WORDS - 1)) || bus.in_last))
                close = 1'b1;
            if (bus.flush && (line_mask != '0))
                close = 1'b1;
            if (!accept && (asm_mask_q != '0) && (idle_q == IDLE_W'(FLUSH_TIMEOUT)))
                close = 1'b1;
        end

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;

        case (state_q)
            S_FILL: begin
                asm_data_d = line_data;
                asm_mask_d = line_mask;
                if (accept)
                    cnt_d = cnt_q + 1'b1;
                if (close) begin
                    if (out_free) begin
                        load_en   = 1'b1;
                        load_data = line_data;
                        load_mask = line_mask;
                    end else begin
                        state_d = S_PEND;
                    end
                end
                if (!accept && !close && (asm_mask_q != '0))
                    idle_d = idle_q + 1'b1;
            end
            S_PEND: begin
                if (out_free) begin
                    load_en = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase

        // A line leaving the assembly empties it so the next word lands in slot 0
        if (load_en) begin
            out_valid_d = 1'b1;
            out_frame_d = {!(&load_mask), load_data};
            out_mask_d  = load_mask;
            asm_data_d  = '0;
            asm_mask_d  = '0;
            cnt_d       = '0;
        end
    end

    // State registers; reset discards every buffered line immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            cnt_q       <= '0;
            asm_data_q  <= '0;
            asm_mask_q  <= '0;
            idle_q      <= '0;
            out_valid_q <= 1'b0;
            out_frame_q <= '0;
            out_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_data_q  <= asm_data_d;
            asm_mask_q  <= asm_mask_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_frame_q <= out_frame_d;
            out_mask_q  <= out_mask_d;
        end
    end
endmodule

// File: tb/tb_mem_line_packer.sv
// tb/tb_mem_line_packer.sv - directed self-checking bench for mem_line_packer
module tb_mem_line_packer;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   stalls   = 0;

    logic [128:0] got_frame[$];
    logic [3:0]   got_mask[$];

    mem_line_packer_if #(.WORD_W(32), .WORDS(4)) bus ();

    mem_line_packer #(.WORD_W(32), .WORDS(4), .FLUSH_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Record every frame the consumer takes; inputs change only just after posedge
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            got_frame.push_back(bus.out_frame);
            got_mask.push_back(bus.out_mask);
        end
    end

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] data, input logic last);
        int b;
        b = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        while (!bus.in_ready && b < 200) begin
            step();
            b++;
        end
        if (b >= 200) begin
            n_checks++;
            $error("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
        end
        if (b > 0) stalls++;
        step();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        logic [31:0]  w[12];
        logic [128:0] f;
        int           n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_frame", bus.out_frame, 0);
        check("rst_out_mask", bus.out_mask, 0);
        rst = 1'b0;
        step();
        check("rst_in_ready", bus.in_ready, 1);

        // Full-line stream with out_ready high
        stalls = 0;
        for (int i = 0; i < 4; i++) send(32'h11111111 * (i + 1), 1'b0);
        check("s0_valid", bus.out_valid, 1);
        check("s0_frame", bus.out_frame, {1'b0, 128'h44444444_33333333_22222222_11111111});
        check("s0_mask", bus.out_mask, 4'hF);
        for (int i = 4; i < 8; i++) send(32'h11111111 * (i + 1), 1'b0);
        check("s1_valid", bus.out_valid, 1);
        check("s1_frame", bus.out_frame, {1'b0, 128'h88888888_77777777_66666666_55555555});
        step();
        check("s_count", got_frame.size(), 2);
        check("s_q0", got_frame[0], {1'b0, 128'h44444444_33333333_22222222_11111111});
        check("s_q1", got_frame[1], {1'b0, 128'h88888888_77777777_66666666_55555555});
        check("s_stalls", stalls, 0);
        got_frame.delete();
        got_mask.delete();

        // Short line closed by in_last
        send(32'h0000000A, 1'b0);
        send(32'h0000000B, 1'b1);
        check("last_valid", bus.out_valid, 1);
        check("last_frame", bus.out_frame, {1'b1, 128'h00000000_00000000_0000000B_0000000A});
        check("last_mask", bus.out_mask, 4'h3);
        step();
        got_frame.delete();
        got_mask.delete();

        // Idle timeout closes a 3-word line
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        send(32'h00000003, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        check("to_latency", n, T + 1);
        check("to_frame", bus.out_frame, {1'b1, 128'h00000000_00000003_00000002_00000001});
        check("to_mask", bus.out_mask, 4'h7);
        step();
        check("to_count", got_frame.size(), 1);

        // Flush on an empty packer emits nothing
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("fe_valid", bus.out_valid, 0);
        check("fe_count", got_frame.size(), 1);
        got_frame.delete();
        got_mask.delete();

        // Backpressure: two lines buffered, then in_ready drops
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) w[i] = 32'hC0DE0000 + i;
        for (int i = 0; i < 8; i++) send(w[i], 1'b0);
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_hold0", bus.out_frame, {1'b0, w[3], w[2], w[1], w[0]});
        for (int i = 0; i < 3; i++) step();
        check("bp_hold1", bus.out_frame, {1'b0, w[3], w[2], w[1], w[0]});
        check("bp_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        for (int i = 8; i < 12; i++) send(w[i], 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("bp_count", got_frame.size(), 3);
        for (int k = 0; k < 3; k++) begin
            f = (got_frame.size() > k) ? got_frame[k] : '0;
            check($sformatf("bp_q%0d", k), f, {1'b0, w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]});
        end
        got_frame.delete();
        got_mask.delete();

        // Flush in the same cycle as the first word
        bus.flush = 1'b1;
        send(32'h0000000C, 1'b0);
        bus.flush = 1'b0;
        check("fw_valid", bus.out_valid, 1);
        check("fw_frame", bus.out_frame, {1'b1, 128'h0000000C});
        check("fw_mask", bus.out_mask, 4'h1);
        step();
        got_frame.delete();
        got_mask.delete();

        // Reset with one frame held and two words assembled
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(32'hDEAD0000 + i, 1'b0);
        check("mr_pre_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check("mr_async_valid", bus.out_valid, 0);
        step();
        rst = 1'b0;
        step();
        check("mr_in_ready", bus.in_ready, 1);
        check("mr_mask", bus.out_mask, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(32'hBEEF0000 + i, 1'b0);
        check("mr_frame", bus.out_frame, {1'b0, 128'hBEEF0003_BEEF0002_BEEF0001_BEEF0000});
        check("mr_fmask", bus.out_mask, 4'hF);
        for (int i = 0; i < 20; i++) step();
        check("mr_count", got_frame.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_line_packer.md
Name: mem_line_packer

Overview:
- Upstream feeder for the 129-bit memory bus port of `main`.
- Accepts a stream of 32-bit words on a valid/ready interface and packs them into 128-bit lines.
- Emits each line as a 129-bit frame `{partial, line}` on a second valid/ready interface.
- Double-buffered (one assembly register plus one output register), with flush on `in_last`, external `flush`, or idle timeout.

Parameters:
- WORD_W, 32, input word width
- WORDS, 4, words per line; WORD_W*WORDS = 128 (fixed for this bus)
- FLUSH_TIMEOUT, 16, idle cycles before a partially filled line is closed (≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  word available
- in_ready  output  1  packer can accept a word this cycle
- in_data  input  32  word; slot k occupies line bits [32k+31:32k]
- in_last  input  1  word ends the current line (qualified by in_valid)
- flush  input  1  close the current partial line (single-cycle pulse)
- out_valid  output  1  frame valid
- out_ready  input  1  consumer takes the frame
- out_frame  output  129  bit 128 = partial flag; [127:0] = line
- out_mask  output  4  per-word valid mask of out_frame

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_frame=0, out_mask=0.
  - Slot counter = 0, assembly mask = 0, idle counter = 0, pending = 0.
  - in_ready=1 once rst is low.
- Transfer rules:
  - A word is accepted when in_valid && in_ready at a rising edge.
  - A frame is consumed when out_valid && out_ready.
- in_ready = !pending. It does not depend on in_valid, in_data or in_last.
- Accepting a word:
  - in_data is written to slot `cnt`, mask bit `cnt` is set, and `cnt` increments.
  - The line closes if `cnt` was WORDS-1 or in_last=1.
- Closing a line at edge N:
  - Output register free: the register is free if out_valid=0, or if out_valid && out_ready at edge N.
  - If free, the line moves to the output register at edge N, so out_valid=1 in cycle N+1. Minimum latency is 1 cycle from the completing word.
  - Assembly then clears (cnt=0, mask=0) and accepts again in cycle N+1.
  - If not free, pending=1 and the assembly holds. The line transfers at the first edge where the output register frees; pending then clears. in_ready is low throughout pending.
- Frame contents:
  - Unfilled slots are zero.
  - out_frame[128] = (out_mask != 4'b1111).
  - out_frame and out_mask stay stable while out_valid && !out_ready.
- Flush:
  - When flush=1 and the assembly holds ≥1 word and is not pending, the line closes at that edge.
  - A word accepted in the same cycle is included.
  - Flush is ignored when the assembly is empty (and no word is accepted that cycle) or pending. No zero-mask frame is ever emitted.
- Idle timeout:
  - The counter increments each cycle the assembly is non-empty, not pending, and no word is accepted.
  - It resets to 0 on any accept, on any close, and while empty.
  - Reaching FLUSH_TIMEOUT closes the line exactly as flush does.
- Coincident events are treated as a single close.
- Throughput:
  - Steady stream with out_ready=1: one word per cycle and one frame per WORDS cycles, with no bubbles.
  - out_ready=0: at most 2 lines are buffered, then in_ready drops.
- Reset mid-operation:
  - Buffered lines are discarded.
  - out_valid drops immediately (async) and no partial frame is emitted afterward.

Test Plan:
- Stream 8 words 0x11111111..0x88888888, in_valid=1, out_ready=1 → frame 0 = {0, 0x44444444_33333333_22222222_11111111}, mask 4'hF, out_valid in cycle after 4th accept; frame 1 likewise with 0x55555555..0x88888888; in_ready never low.
- 2 words 0xA, 0xB with in_last on 2nd → frame {1, 0x0000000B_0000000A} (i.e. bit128=1, slots 2,3 zero), mask 4'h3.
- 3 words then idle, out_ready=1 → partial frame (mask 4'h7, bit128=1) appears exactly FLUSH_TIMEOUT+1 cycles after the 3rd accept; flush pulse on an empty packer → no frame.
- out_ready=0, stream 12 words → in_ready drops after 8th accept; frame 0 held stable; raise out_ready → frames 0,1,2 emitted in order with no loss or duplication.
- flush in same cycle as accepting 1st word 0xC → frame with mask 4'h1, data slot0=0xC, bit128=1.
- Assert rst with 2 words assembled and 1 frame pending → out_valid=0 asynchronously; after release in_ready=1, next 4 words produce a clean full frame.
